// File: rtl/hilo_muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hilo_muldiv_unit_pkg
// Brief   : Shared widths, reset level and divider FSM encodings for the
//           HI/LO multiply/divide unit.
// Revision: 1.0 - initial release
// ============================================================================
package hilo_muldiv_unit_pkg;

   localparam int                    DATALENGTH = 32;
   localparam logic [DATALENGTH-1:0] ZEROWORD   = '0;
   localparam logic                  RESETABLE  = 1'b0;
   localparam int                    DIV_ITER   = 32;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_RUN  = 2'd1,
      MD_DONE = 2'd2
   } md_state_t;

endpackage
`default_nettype wire

// File: rtl/hilo_muldiv_unit_div_restoring.sv
`default_nettype none
// ============================================================================
// Module  : hilo_muldiv_unit_div_restoring
// Brief   : 32-iteration restoring divider with sign fix-up, divide-by-zero
//           override and E-stage stall generation.
// Revision: 1.0 - initial release
// ============================================================================
module hilo_muldiv_unit_div_restoring
   import hilo_muldiv_unit_pkg::*;
#(
   parameter int DATA_W = DATALENGTH,
   parameter int ITER   = hilo_muldiv_unit_pkg::DIV_ITER
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              flush,
   input  logic              hold,
   input  logic              is_signed,
   input  logic [DATA_W-1:0] src_a,
   input  logic [DATA_W-1:0] src_b,
   output logic              stall,
   output logic              done,
   output logic [DATA_W-1:0] quo,
   output logic [DATA_W-1:0] rem
);

   localparam int CNT_W = $clog2(ITER);

   md_state_t         r_state;
   md_state_t         w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_rem;
   logic [DATA_W-1:0] r_quo;
   logic [DATA_W-1:0] r_dvs;
   logic [DATA_W-1:0] r_src_a;
   logic              r_sign_a;
   logic              r_sign_b;
   logic              r_signed;
   logic              r_div_zero;

   logic              w_sign_a;
   logic              w_sign_b;
   logic              w_go;
   logic              w_last;
   logic              w_ge;
   logic [DATA_W-1:0] w_abs_a;
   logic [DATA_W-1:0] w_abs_b;
   logic [DATA_W:0]   w_rem_sh;
   logic [DATA_W:0]   w_diff;
   logic [DATA_W-1:0] w_quo_fix;
   logic [DATA_W-1:0] w_rem_fix;

   assign w_sign_a = is_signed & src_a[DATA_W-1];
   assign w_sign_b = is_signed & src_b[DATA_W-1];
   assign w_abs_a  = w_sign_a ? -src_a : src_a;
   assign w_abs_b  = w_sign_b ? -src_b : src_b;
   assign w_go     = start & ~flush;
   assign w_last   = (r_cnt == CNT_W'(ITER - 1));

   // The partial remainder is always below the divisor, so bit DATA_W of the
   // difference is a clean borrow flag for the trial subtract.
   assign w_rem_sh = {r_rem, r_quo[DATA_W-1]};
   assign w_diff   = w_rem_sh - {1'b0, r_dvs};
   assign w_ge     = ~w_diff[DATA_W];

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         MD_IDLE: if (w_go)   w_state_nxt = MD_RUN;
         MD_RUN:  if (w_last) w_state_nxt = MD_DONE;
         MD_DONE: if (!hold)  w_state_nxt = MD_IDLE;
         default:             w_state_nxt = MD_IDLE;
      endcase
      if (flush) w_state_nxt = MD_IDLE;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (reset == RESETABLE) begin
         r_state    <= MD_IDLE;
         r_cnt      <= '0;
         r_rem      <= '0;
         r_quo      <= '0;
         r_dvs      <= '0;
         r_src_a    <= '0;
         r_sign_a   <= 1'b0;
         r_sign_b   <= 1'b0;
         r_signed   <= 1'b0;
         r_div_zero <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if ((r_state == MD_IDLE) && w_go) begin
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quo      <= w_abs_a;
            r_dvs      <= w_abs_b;
            r_src_a    <= src_a;
            r_sign_a   <= w_sign_a;
            r_sign_b   <= w_sign_b;
            r_signed   <= is_signed;
            r_div_zero <= (src_b == '0);
         end else if ((r_state == MD_RUN) && !flush) begin
            r_cnt <= r_cnt + 1'b1;
            r_rem <= w_ge ? w_diff[DATA_W-1:0] : w_rem_sh[DATA_W-1:0];
            r_quo <= {r_quo[DATA_W-2:0], w_ge};
         end
      end
   end

   assign w_quo_fix = (r_signed & (r_sign_a ^ r_sign_b)) ? -r_quo : r_quo;
   assign w_rem_fix = (r_signed & r_sign_a) ? -r_rem : r_rem;

   assign quo   = r_div_zero ? '1      : w_quo_fix;
   assign rem   = r_div_zero ? r_src_a : w_rem_fix;
   assign done  = (r_state == MD_DONE);
   assign stall = w_go & (r_state != MD_DONE);

endmodule
`default_nettype wire

// File: rtl/hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module  : hilo_muldiv_unit
// Brief   : HI/LO register owner: single-cycle multiplier, iterative divider
//           in E, and W-stage MFHI/MFLO result selection.
// Revision: 1.0 - initial release
// ============================================================================
module hilo_muldiv_unit
   import hilo_muldiv_unit_pkg::*;
#(
   parameter int DATA_W   = DATALENGTH,
   parameter int DIV_ITER = hilo_muldiv_unit_pkg::DIV_ITER
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              MulStartE,
   input  logic              DivStartE,
   input  logic              MdSignedE,
   input  logic [DATA_W-1:0] SrcAE,
   input  logic [DATA_W-1:0] SrcBE,
   input  logic              FlushE,
   input  logic              HoldE,
   output logic              MdStallE,
   output logic [DATA_W-1:0] MdHiE,
   output logic [DATA_W-1:0] MdLoE,
   input  logic              HiWriteW,
   input  logic              LoWriteW,
   input  logic [DATA_W-1:0] HiDataW,
   input  logic [DATA_W-1:0] LoDataW,
   input  logic              MFHiW,
   input  logic              MFLoW,
   input  logic [DATA_W-1:0] ResultW,
   output logic [DATA_W-1:0] ResultW_withHilo
);

   logic [DATA_W-1:0]   r_hi;
   logic [DATA_W-1:0]   r_lo;
   logic [DATA_W-1:0]   w_mul_a;
   logic [DATA_W-1:0]   w_mul_b;
   logic [2*DATA_W-1:0] w_a_ext;
   logic [2*DATA_W-1:0] w_b_ext;
   logic [2*DATA_W-1:0] w_prod;
   logic                w_div_done;
   logic [DATA_W-1:0]   w_div_quo;
   logic [DATA_W-1:0]   w_div_rem;

   // Operands are isolated when no multiply is in E; sign/zero extension to
   // the full product width makes one unsigned multiply serve both forms.
   assign w_mul_a = MulStartE ? SrcAE : '0;
   assign w_mul_b = MulStartE ? SrcBE : '0;
   assign w_a_ext = {{DATA_W{MdSignedE & w_mul_a[DATA_W-1]}}, w_mul_a};
   assign w_b_ext = {{DATA_W{MdSignedE & w_mul_b[DATA_W-1]}}, w_mul_b};
   assign w_prod  = w_a_ext * w_b_ext;

   hilo_muldiv_unit_div_restoring #(
      .DATA_W (DATA_W),
      .ITER   (DIV_ITER)
   ) u_div (
      .clock     (clock),
      .reset     (reset),
      .start     (DivStartE),
      .flush     (FlushE),
      .hold      (HoldE),
      .is_signed (MdSignedE),
      .src_a     (SrcAE),
      .src_b     (SrcBE),
      .stall     (MdStallE),
      .done      (w_div_done),
      .quo       (w_div_quo),
      .rem       (w_div_rem)
   );

   assign MdHiE = w_div_done ? w_div_rem : w_prod[2*DATA_W-1:DATA_W];
   assign MdLoE = w_div_done ? w_div_quo : w_prod[DATA_W-1:0];

   always_ff @(posedge clock or negedge reset) begin
      if (reset == RESETABLE) begin
         r_hi <= '0;
         r_lo <= '0;
      end else begin
         if (HiWriteW) r_hi <= HiDataW;
         if (LoWriteW) r_lo <= LoDataW;
      end
   end

   always_comb begin
      ResultW_withHilo = ResultW;
      if (reset == RESETABLE) ResultW_withHilo = DATA_W'(ZEROWORD);
      else if (MFHiW)         ResultW_withHilo = r_hi;
      else if (MFLoW)         ResultW_withHilo = r_lo;
   end

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_hilo_muldiv_unit
// Brief   : Scoreboard bench for hilo_muldiv_unit with directed vectors.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_hilo_muldiv_unit;
   import hilo_muldiv_unit_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        MulStartE = 1'b0, DivStartE = 1'b0, MdSignedE = 1'b0;
   logic [31:0] SrcAE = '0, SrcBE = '0;
   logic        FlushE = 1'b0, HoldE = 1'b0;
   logic        MdStallE;
   logic [31:0] MdHiE, MdLoE;
   logic        HiWriteW = 1'b0, LoWriteW = 1'b0;
   logic [31:0] HiDataW = '0, LoDataW = '0;
   logic        MFHiW = 1'b0, MFLoW = 1'b0;
   logic [31:0] ResultW = '0;
   logic [31:0] ResultW_withHilo;
   logic        w_probe = 1'b0;

   typedef struct {
      string       name;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   exp_t md_q[$];
   exp_t w_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clock = ~clock;

   hilo_muldiv_unit dut (
      .clock            (clock),
      .reset            (reset),
      .MulStartE        (MulStartE),
      .DivStartE        (DivStartE),
      .MdSignedE        (MdSignedE),
      .SrcAE            (SrcAE),
      .SrcBE            (SrcBE),
      .FlushE           (FlushE),
      .HoldE            (HoldE),
      .MdStallE         (MdStallE),
      .MdHiE            (MdHiE),
      .MdLoE            (MdLoE),
      .HiWriteW         (HiWriteW),
      .LoWriteW         (LoWriteW),
      .HiDataW          (HiDataW),
      .LoDataW          (LoDataW),
      .MFHiW            (MFHiW),
      .MFLoW            (MFLoW),
      .ResultW          (ResultW),
      .ResultW_withHilo (ResultW_withHilo)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: pops an expectation whenever the DUT presents a result.
   always @(negedge clock) begin
      exp_t e;
      if ((MulStartE || DivStartE) && !FlushE && !MdStallE) begin
         if (md_q.size() == 0) begin
            n_checks++;
            $display("FAIL md_unexpected: got hi=%h lo=%h expected none", MdHiE, MdLoE);
         end else begin
            e = md_q.pop_front();
            check({e.name, "_hi"}, MdHiE, e.hi);
            check({e.name, "_lo"}, MdLoE, e.lo);
         end
      end
      if (w_probe) begin
         if (w_q.size() == 0) begin
            n_checks++;
            $display("FAIL w_unexpected: got %h expected none", ResultW_withHilo);
         end else begin
            e = w_q.pop_front();
            check(e.name, ResultW_withHilo, e.lo);
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hi, input logic [31:0] lo, input string name);
      md_q.push_back('{name, hi, lo});
      MulStartE = 1'b1; MdSignedE = sgn; SrcAE = a; SrcBE = b;
      @(negedge clock);
      check({name, "_stall"}, 32'(MdStallE), 32'd0);
      step();
      MulStartE = 1'b0;
   endtask

   task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hi, input logic [31:0] lo, input string name,
                         input int hold);
      int n = 0;
      md_q.push_back('{name, hi, lo});
      DivStartE = 1'b1; MdSignedE = sgn; SrcAE = a; SrcBE = b;
      @(negedge clock);
      while (MdStallE && n < 100) begin
         n++;
         @(negedge clock);
      end
      check({name, "_stall_cycles"}, 32'(n), 32'd33);
      if (hold > 0) begin
         HoldE = 1'b1;
         for (int h = 0; h < hold; h++) begin
            md_q.push_back('{name, hi, lo});
            @(negedge clock);
            check({name, "_hold_stall"}, 32'(MdStallE), 32'd0);
         end
         HoldE = 1'b0;
      end
      step();
      DivStartE = 1'b0;
      check({name, "_idle"}, 32'(dut.u_div.r_state), 32'(MD_IDLE));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset with an MFHI in W: output forced to zero.
      MFHiW = 1'b1; w_probe = 1'b1; ResultW = 32'hDEAD_BEEF;
      w_q.push_back('{"rst_result", 32'h0, 32'h0});
      @(negedge clock);
      check("rst_stall", 32'(MdStallE), 32'd0);
      step();
      reset = 1'b1; MFHiW = 1'b0; w_probe = 1'b0;
      step();

      do_mul(1'b1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult_neg");
      do_mul(1'b0, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, "multu");
      do_mul(1'b0, 32'h1234_5678, 32'h10, 32'h0000_0001, 32'h2345_6780, "multu_shift");
      do_mul(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, "mult_m1m1");

      do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2", 0);
      do_div(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, "divu_100_7", 0);
      do_div(1'b0, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, "divu_zero", 0);
      do_div(1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_zero_s", 0);
      do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, "div_ovf", 0);

      // HI/LO write then MF read-back, plus priority and passthrough.
      HiWriteW = 1'b1; HiDataW = 32'hA5A5_A5A5;
      step();
      HiWriteW = 1'b0; MFHiW = 1'b1; w_probe = 1'b1; ResultW = 32'h1111_1111;
      w_q.push_back('{"mfhi", 32'h0, 32'hA5A5_A5A5});
      step();
      MFHiW = 1'b0; w_probe = 1'b0; LoWriteW = 1'b1; LoDataW = 32'h5A5A_0F0F;
      step();
      LoWriteW = 1'b0; MFLoW = 1'b1; w_probe = 1'b1;
      w_q.push_back('{"mflo", 32'h0, 32'h5A5A_0F0F});
      step();
      MFHiW = 1'b1;
      w_q.push_back('{"mf_both", 32'h0, 32'hA5A5_A5A5});
      step();
      MFHiW = 1'b0; MFLoW = 1'b0; ResultW = 32'h1234_5678;
      w_q.push_back('{"passthru", 32'h0, 32'h1234_5678});
      step();
      w_probe = 1'b0;

      // Flush at RUN cycle 10, then a fresh divide.
      DivStartE = 1'b1; MdSignedE = 1'b1; SrcAE = 32'd1000; SrcBE = 32'd3;
      for (int i = 0; i < 11; i++) step();
      FlushE = 1'b1;
      @(negedge clock);
      check("flush_stall", 32'(MdStallE), 32'd0);
      step();
      check("flush_idle", 32'(dut.u_div.r_state), 32'(MD_IDLE));
      FlushE = 1'b0; DivStartE = 1'b0;
      step();
      do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, "div_after_flush", 0);

      do_div(1'b0, 32'd1000, 32'd33, 32'd10, 32'd30, "divu_hold", 3);

      // Reset mid-divide with HI holding data.
      DivStartE = 1'b1; MdSignedE = 1'b0; SrcAE = 32'd500; SrcBE = 32'd9;
      for (int i = 0; i < 5; i++) step();
      reset = 1'b0; DivStartE = 1'b0; MFHiW = 1'b1; w_probe = 1'b1;
      w_q.push_back('{"midrst_result", 32'h0, 32'h0});
      @(negedge clock);
      check("midrst_state", 32'(dut.u_div.r_state), 32'(MD_IDLE));
      step();
      reset = 1'b1; ResultW = 32'h7777_7777;
      w_q.push_back('{"rst_hi", 32'h0, 32'h0});
      step();
      MFHiW = 1'b0; MFLoW = 1'b1;
      w_q.push_back('{"rst_lo", 32'h0, 32'h0});
      @(negedge clock);
      check("post_rst_stall", 32'(MdStallE), 32'd0);
      step();
      MFLoW = 1'b0; w_probe = 1'b0;
      step();

      check("md_q_empty", 32'(md_q.size()), 32'd0);
      check("w_q_empty", 32'(w_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Upstream neighbour of the writeback result mux that adds PC+8 for link instructions.
- Owns the HI/LO architectural registers.
- Runs MULT/MULTU as single-cycle and DIV/DIVU as a 32-iteration restoring divider in the E stage, stalling E while dividing.
- Provides the W-stage MFHI/MFLO selection that produces ResultW_withHilo.

Parameters:
- DATA_W, 32, operand/register width; DATALENGTH/ZEROWORD/RESETABLE come from defines.vh.
- DIV_ITER, 32, divider iterations; must equal DATA_W.

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low (RESETABLE = 1'b0); clears all state immediately
- MulStartE  in  1  MULT/MULTU in E
- DivStartE  in  1  DIV/DIVU in E
- MdSignedE  in  1  1 = signed op
- SrcAE  in  32  rs operand (dividend / multiplicand)
- SrcBE  in  32  rt operand (divisor / multiplier)
- FlushE  in  1  E instruction killed (exception/branch); aborts divide
- HoldE  in  1  external stall holding E (not caused by this block)
- MdStallE  out  1  divider busy; freezes F/D/E
- MdHiE  out  32  HI result of E op (remainder / product[63:32])
- MdLoE  out  32  LO result of E op (quotient / product[31:0])
- HiWriteW  in  1  write HI at W (carried MULT/DIV result or MTHI)
- LoWriteW  in  1  write LO at W
- HiDataW  in  32  HI write data
- LoDataW  in  32  LO write data
- MFHiW  in  1  W instruction is MFHI
- MFLoW  in  1  W instruction is MFLO
- ResultW  in  32  ordinary W result (ALU/load)
- ResultW_withHilo  out  32  W result after HI/LO selection

Behaviour:
- Reset (reset==0, async):
  - HI=LO=0; FSM=IDLE; iteration counter=0; divider datapath regs=0.
  - ResultW_withHilo=ZEROWORD.
  - MdStallE is combinational and follows the equation below; with FSM in IDLE and no DivStartE it is 0.
- HI/LO write: HI/LO are written only at W, on the clock edge, from HiDataW/LoDataW. A W instruction cannot both read and write HI/LO, so no bypass is needed.
- ResultW_withHilo priority, combinational: reset → 0; MFHiW → HI; MFLoW → LO; otherwise ResultW. MFHiW and MFLoW together is illegal; MFHiW wins.
- Multiply:
  - MdHiE/MdLoE = 64-bit product of SrcAE×SrcBE in the same cycle, signed or unsigned per MdSignedE.
  - Latency 0, MdStallE=0.
- Divider FSM (IDLE, RUN, DONE):
  - IDLE:
    - DivStartE && !FlushE → latch |A|,|B| (unsigned ops: raw values), signA, signB, MdSignedE; counter=0; go RUN.
    - Otherwise stay in IDLE.
  - RUN: one restoring step per cycle (shift remainder:quotient left 1, trial subtract, set quotient bit). Counter increments; at counter==DIV_ITER-1 go DONE.
  - DONE:
    - MdLoE/MdHiE = sign-corrected quotient/remainder: quotient negated if signed && (signA^signB); remainder negated if signed && signA.
    - Stay in DONE while HoldE=1; go IDLE when HoldE=0.
  - MdStallE = DivStartE && !FlushE && (FSM != DONE). It is 1 in the start cycle and in every RUN cycle, giving 33 stall cycles and a 34-cycle E occupancy.
  - MdHiE/MdLoE are valid only when MdStallE=0; during RUN they are don't-care but held stable.
- FlushE in any state → IDLE at the next edge, no result produced; MdStallE drops in the same cycle.
- Divide by zero: normal 34-cycle latency; result forced to LO=32'hFFFF_FFFF, HI=SrcA, signed or unsigned.
- Signed overflow 0x8000_0000 / 0xFFFF_FFFF: LO=0x8000_0000, HI=0.
- Reset asserted mid-divide: immediate return to IDLE, no HI/LO update.
- HI/LO ordering: older in-flight HiWriteW/LoWriteW commits continue while E is stalled. HI/LO is never written from E.

Decomposition:
- defines.vh (shared): DATALENGTH, ZEROWORD, RESETABLE; add DIV_ITER and 2-bit FSM state encodings MD_IDLE/MD_RUN/MD_DONE.
- One sub-module is natural: div_restoring (FSM, counter, datapath, sign fix).
- Multiplier and HI/LO/MF mux stay in the top level.

Test Plan:
- Reset: reset=0 mid-run with MFHiW=1 → ResultW_withHilo=0; after release HI=LO=0, FSM IDLE, MdStallE=0.
- MULT signed 0xFFFF_FFFE × 3 → MdHiE=0xFFFF_FFFF, MdLoE=0xFFFF_FFFA same cycle, MdStallE=0. MULTU same operands → MdHiE=0x2, MdLoE=0xFFFF_FFFA.
- DIV signed −7 / 2 → MdStallE high 33 cycles, then MdLoE=0xFFFF_FFFD, MdHiE=0xFFFF_FFFF. DIVU 100/7 → LO=14, HI=2.
- Divide by zero, DIVU 0x1234/0 → after 33 stall cycles LO=0xFFFF_FFFF, HI=0x1234. Signed 0x8000_0000/−1 → LO=0x8000_0000, HI=0.
- FlushE asserted at RUN cycle 10 → MdStallE=0 that cycle, FSM IDLE next edge. A new DIV issued right after completes with correct values.
- HiWriteW=1, HiDataW=0xA5A5_A5A5; next cycle MFHiW=1 → ResultW_withHilo=0xA5A5_A5A5. HoldE=1 held 3 cycles in DONE → result stable, MdStallE=0, FSM returns IDLE when HoldE falls.
